serial_add_sched: RTL and testbench

Scheduler and sequencer for the team's bit-serial adder datapath. It accepts parallel operand pairs from two requesters over latency-insensitive val/rdy interfaces and arbitrates between them round-robin. It streams the granted pair LSB-first through a one-bit serial add stage, one bit per cycle, collects the sum bits, and returns the parallel sum, carry-out and requester id on a val/rdy response interface. It sits between parallel-word producers and the serial adder, so it owns all bit sequencing and carry clearing.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_bit.sv | 36 +++
 rtl/serial_add_sched.sv | 125 ++++++++++++
 tb/tb_serial_add_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the serial_add_sched slice.
//   state_t       - sequencer states (IDLE / CALC / DONE)
//   req_id_t      - requester id, 0 or 1
//   NBITS_DEFAULT - default operand/sum width
package serial_add_pkg;

  localparam int NBITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/serial_add_bit.sv
// serial_add_bit: one-bit full adder with its carry register.
//   clk, reset    - clock, asynchronous active-low reset
//   clr           - clear the carry (start of a new operation)
//   en            - advance the carry register by one bit position
//   a, b          - operand bits for the current position
//   sum           - combinational sum bit (a ^ b ^ carry)
//   cout_next     - combinational carry out of the current position
module serial_add_bit (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout_next
);

  logic carry;

  assign sum       = a ^ b ^ carry;
  assign cout_next = (a & b) | (carry & (a ^ b));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= cout_next;
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler and bit sequencer for the serial adder.
//   clk, reset               - clock, asynchronous active-low reset
//   req0_* / req1_*          - val/rdy operand requests (a, b) from two requesters
//   resp_val / resp_rdy      - val/rdy handshake for the result
//   resp_sum                 - (a + b) mod 2^NBITS
//   resp_cout                - carry out of bit NBITS-1
//   resp_id                  - requester that issued the operation
// One operation takes NBITS+2 cycles minimum: IDLE (grant), NBITS x CALC, DONE.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic [NBITS-1:0] req0_a,
  input  logic [NBITS-1:0] req0_b,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic [NBITS-1:0] req1_a,
  input  logic [NBITS-1:0] req1_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_sum,
  output logic             resp_cout,
  output req_id_t          resp_id
);

  localparam int             CW   = $clog2(NBITS);
  localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

  state_t           state, state_nxt;
  logic             prio;          // requester that wins when both are valid
  logic [CW-1:0]    cnt;           // current bit position during CALC
  logic [NBITS-1:0] a_q, b_q;      // latched operands
  logic [NBITS-1:0] sum_sr;        // sum bits shifted in LSB-first
  req_id_t          id_q;
  logic             grant0, grant1, take, calc, last_bit;
  logic             bit_sum, bit_cout;

  assign take     = grant0 | grant1;
  assign calc     = (state == CALC);
  assign last_bit = calc && (cnt == LAST);
  assign resp_val = (state == DONE);
  assign req0_rdy = grant0;
  assign req1_rdy = grant1;

  serial_add_bit u_bit (
    .clk       (clk),
    .reset     (reset),
    .clr       (take),
    .en        (calc),
    .a         (a_q[cnt]),
    .b         (b_q[cnt]),
    .sum       (bit_sum),
    .cout_next (bit_cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        // Grants are masked by reset so rdy is 0 while the block is held.
        if (reset) begin
          grant0 = req0_val && (!req1_val || !prio);
          grant1 = req1_val && (!req0_val ||  prio);
        end
        if (grant0 || grant1) state_nxt = CALC;
      end
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (resp_rdy)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand and sum registers are reset along with the control state so
  // the response outputs come out of reset at 0 with no X propagation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio      <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_sr    <= '0;
      id_q      <= 1'b0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_id   <= 1'b0;
    end else begin
      if (take) begin
        a_q  <= grant1 ? req1_a : req0_a;
        b_q  <= grant1 ? req1_b : req0_b;
        id_q <= grant1;
        prio <= !grant1;           // next tie goes to the other requester
        cnt  <= '0;
      end
      if (calc) begin
        sum_sr <= {bit_sum, sum_sr[NBITS-1:1]};
        cnt    <= cnt + 1'b1;
      end
      // Response registers change only when a result completes, so they
      // hold their previous value through IDLE and CALC.
      if (last_bit) begin
        resp_sum  <= {bit_sum, sum_sr[NBITS-1:1]};
        resp_cout <= bit_cout;
        resp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: self-checking bench for serial_add_sched (NBITS = 4).
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. Expected results come from plain integer addition.
module tb_serial_add_sched;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_val = 1'b0, req1_val = 1'b0;
  logic          req0_rdy, req1_rdy;
  logic [NB-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          resp_val, resp_rdy = 1'b0;
  logic [NB-1:0] resp_sum;
  logic          resp_cout;
  logic          resp_id;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];   // {id, cout, sum} in grant order

  serial_add_sched #(.NBITS(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout),
    .resp_id   (resp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] model(input logic id, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b};
    return {id, t};
  endfunction

  function automatic logic [5:0] resp_word();
    return {resp_id, resp_cout, resp_sum};
  endfunction

  // Issue one operation with resp_rdy=1 and capture the response word.
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       output logic [5:0] w, output bit ok);
    bit got;
    ok = 1'b0;
    w  = '0;
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    if (id) begin req1_val = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_val = 1'b1; req0_a = a; req0_b = b; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? req1_rdy : req0_rdy;
    end
    @(posedge clk); #1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    if (got) begin
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (resp_val) begin ok = 1'b1; w = resp_word(); end
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b0;
    req0_val = 1'b1;
    req1_val = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req0_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_req0_rdy: got %b expected 0", req0_rdy); end
    n_cmp++; if (req1_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_req1_rdy: got %b expected 0", req1_rdy); end
    n_cmp++; if (resp_val !== 1'b0) begin n_bad++; $display("FAIL reset_resp_val: got %b expected 0", resp_val); end
    n_cmp++; if (resp_sum !== 4'h0) begin n_bad++; $display("FAIL reset_resp_sum: got %h expected 0", resp_sum); end
    n_cmp++; if (resp_cout !== 1'b0) begin n_bad++; $display("FAIL reset_resp_cout: got %b expected 0", resp_cout); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL reset_resp_id: got %b expected 0", resp_id); end
    @(posedge clk); #1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int first;
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    req0_val = 1'b1; req0_a = 4'b0011; req0_b = 4'b0010;
    @(negedge clk);
    n_cmp++; if (req0_rdy !== 1'b1) begin n_bad++; $display("FAIL single_req0_rdy: got %b expected 1", req0_rdy); end
    n_cmp++; if (req1_rdy !== 1'b0) begin n_bad++; $display("FAIL single_req1_rdy: got %b expected 0", req1_rdy); end
    @(posedge clk); #1;
    req0_val = 1'b0;
    first = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      @(negedge clk);
      if (resp_val) first = k;
    end
    n_cmp++; if (first != 5) begin n_bad++; $display("FAIL single_latency: got %0d expected 5", first); end
    n_cmp++; if (resp_sum !== 4'b0101) begin n_bad++; $display("FAIL single_sum: got %b expected 0101", resp_sum); end
    n_cmp++; if (resp_cout !== 1'b0) begin n_bad++; $display("FAIL single_cout: got %b expected 0", resp_cout); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b expected 0", resp_id); end
    @(negedge clk);
    n_cmp++; if (resp_val !== 1'b0) begin n_bad++; $display("FAIL single_resp_done: got %b expected 0", resp_val); end
  endtask

  task automatic test_overflow();
    logic       ids [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0] as  [3] = '{4'b1111, 4'b1000, 4'b0100};
    logic [3:0] bs  [3] = '{4'b0001, 4'b1000, 4'b0100};
    logic [5:0] exps[3] = '{6'b1_1_0000, 6'b0_1_0000, 6'b0_0_1000};
    logic [5:0] w;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(ids[i], as[i], bs[i], w, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL overflow_timeout[%0d]: got no response expected %b", i, exps[i]); end
      else if (w !== exps[i]) begin n_bad++; $display("FAIL overflow[%0d]: got %b expected %b", i, w, exps[i]); end
    end
  endtask

  task automatic test_fairness();
    int last, ngr;
    logic gid;
    logic [5:0] e;
    @(posedge clk); #1;
    reset = 1'b0;
    resp_rdy = 1'b1;
    req0_val = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_val = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom);
    @(posedge clk); #1;
    reset = 1'b1;
    last = 0;
    ngr  = 0;
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      gid = req1_rdy;
      n_cmp++; if (req0_rdy && req1_rdy) begin n_bad++; $display("FAIL fair_both_rdy: got 11 expected at most one at cycle %0d", k); end
      if (req0_rdy || req1_rdy) begin
        n_cmp++; if (gid !== ngr[0]) begin n_bad++; $display("FAIL fair_order: got id %b expected %b (grant %0d)", gid, ngr[0], ngr); end
        if (ngr > 0) begin
          n_cmp++; if (k - last != 6) begin n_bad++; $display("FAIL fair_interval: got %0d expected 6", k - last); end
        end
        exp_q.push_back(gid ? model(1'b1, req1_a, req1_b) : model(1'b0, req0_a, req0_b));
        last = k;
        ngr++;
      end
      if (resp_val) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL fair_resp: got %b expected none", resp_word()); end
        else begin
          e = exp_q.pop_front();
          if (resp_word() !== e) begin n_bad++; $display("FAIL fair_resp: got %b expected %b", resp_word(), e); end
        end
      end
      @(posedge clk); #1;
      if (req0_rdy) begin req0_a = 4'($urandom); req0_b = 4'($urandom); end
      if (req1_rdy) begin req1_a = 4'($urandom); req1_b = 4'($urandom); end
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    n_cmp++; if (ngr != 7) begin n_bad++; $display("FAIL fair_grants: got %0d expected 7", ngr); end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      if (resp_val) begin
        e = exp_q.pop_front();
        n_cmp++; if (resp_word() !== e) begin n_bad++; $display("FAIL fair_drain: got %b expected %b", resp_word(), e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fair_pending: got %0d outstanding expected 0", exp_q.size()); end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] a0, b0, a1, b1;
    logic [5:0] hold;
    bit got;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    req0_val = 1'b1; req0_a = a0; req0_b = b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = req0_rdy; end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_grant: got no grant expected req0_rdy"); end
    @(posedge clk); #1;
    req0_val = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = resp_val; end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_resp_timeout: got no resp_val expected 1"); end
    hold = resp_word();
    n_cmp++; if (hold !== model(1'b0, a0, b0)) begin n_bad++; $display("FAIL bp_resp: got %b expected %b", hold, model(1'b0, a0, b0)); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req0_val = 1'b1;
      req1_val = 1'b1; req1_a = a1; req1_b = b1;
      @(negedge clk);
      n_cmp++; if ({resp_val, resp_word()} !== {1'b1, hold}) begin n_bad++; $display("FAIL bp_hold: got %b expected %b", {resp_val, resp_word()}, {1'b1, hold}); end
      n_cmp++; if ({req0_rdy, req1_rdy} !== 2'b00) begin n_bad++; $display("FAIL bp_rdy: got %b expected 00", {req0_rdy, req1_rdy}); end
    end
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (resp_val !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b expected 1", resp_val); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (resp_val !== 1'b0) begin n_bad++; $display("FAIL bp_idle_val: got %b expected 0", resp_val); end
    n_cmp++; if ({req0_rdy, req1_rdy} !== 2'b01) begin n_bad++; $display("FAIL bp_idle_rdy: got %b expected 01", {req0_rdy, req1_rdy}); end
    @(posedge clk); #1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = resp_val; end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL bp_next_timeout: got no resp_val expected 1"); end
    else if (resp_word() !== model(1'b1, a1, b1)) begin n_bad++; $display("FAIL bp_next: got %b expected %b", resp_word(), model(1'b1, a1, b1)); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] a0, b0;
    bit got;
    a0 = 4'($urandom); b0 = 4'($urandom);
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    req0_val = 1'b1; req0_a = 4'hF; req0_b = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = req0_rdy; end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rmid_grant: got no grant expected req0_rdy"); end
    @(posedge clk); #1;       // first CALC cycle
    req0_val = 1'b0;
    @(posedge clk); #1;       // second CALC cycle
    reset = 1'b0;
    req0_val = 1'b1; req0_a = a0; req0_b = b0;
    req1_val = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom);
    #1;
    n_cmp++; if ({resp_val, resp_word(), req0_rdy, req1_rdy} !== 9'b0)
      begin n_bad++; $display("FAIL rmid_immediate: got %b expected 0", {resp_val, resp_word(), req0_rdy, req1_rdy}); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++; if (resp_val !== 1'b0) begin n_bad++; $display("FAIL rmid_resp_val: got %b expected 0", resp_val); end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req0_rdy, req1_rdy} !== 2'b10) begin n_bad++; $display("FAIL rmid_first_grant: got %b expected 10", {req0_rdy, req1_rdy}); end
    @(posedge clk); #1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = resp_val; end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL rmid_resp_timeout: got no resp_val expected 1"); end
    else if (resp_word() !== model(1'b0, a0, b0)) begin n_bad++; $display("FAIL rmid_resp: got %b expected %b", resp_word(), model(1'b0, a0, b0)); end
    @(posedge clk);
  endtask

  task automatic test_random();
    int issued, nresp, cyc;
    logic mprio, gid, exp_g, prev_hold;
    logic [5:0] e, prev_w;
    @(posedge clk); #1;
    reset = 1'b0;
    req0_val = 1'b0;
    req1_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    issued = 0; nresp = 0; cyc = 0;
    mprio = 1'b0;
    prev_hold = 1'b0;
    prev_w = '0;
    while (nresp < 20 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (issued < 20) begin
        req0_val = 1'($urandom_range(0, 1)); req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_val = 1'($urandom_range(0, 1)); req1_a = 4'($urandom); req1_b = 4'($urandom);
      end else begin
        req0_val = 1'b0;
        req1_val = 1'b0;
      end
      resp_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_hold) begin
        n_cmp++; if ({resp_val, resp_word()} !== {1'b1, prev_w}) begin n_bad++; $display("FAIL rand_hold: got %b expected %b", {resp_val, resp_word()}, {1'b1, prev_w}); end
      end
      if (req0_rdy || req1_rdy) begin
        gid   = req1_rdy;
        exp_g = (req0_val && req1_val) ? mprio : req1_val;
        n_cmp++; if ({req0_rdy, req1_rdy} !== {!exp_g, exp_g} || !(exp_g ? req1_val : req0_val))
          begin n_bad++; $display("FAIL rand_grant: got %b expected id %b (vals %b%b)", {req0_rdy, req1_rdy}, exp_g, req0_val, req1_val); end
        exp_q.push_back(gid ? model(1'b1, req1_a, req1_b) : model(1'b0, req0_a, req0_b));
        mprio = !gid;
        issued++;
      end
      if (resp_val) begin
        n_cmp++; if ({req0_rdy, req1_rdy} !== 2'b00) begin n_bad++; $display("FAIL rand_busy_rdy: got %b expected 00", {req0_rdy, req1_rdy}); end
      end
      if (resp_val && resp_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL rand_resp: got %b expected none", resp_word()); end
        else begin
          e = exp_q.pop_front();
          if (resp_word() !== e) begin n_bad++; $display("FAIL rand_resp[%0d]: got %b expected %b", nresp, resp_word(), e); end
        end
        nresp++;
      end
      prev_hold = resp_val && !resp_rdy;
      prev_w    = resp_word();
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    n_cmp++; if (nresp != 20) begin n_bad++; $display("FAIL rand_count: got %0d responses expected 20", nresp); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_pending: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
